// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared types and constants for the two-requester simple-dual-port RAM arbiter.
package sdp_ram_arbiter_pkg;

    localparam int NUM_REQ    = 2;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef logic req_id_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past the winner on accept.
module rr_arb2
    import sdp_ram_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_accept,
    output logic [NUM_REQ-1:0] o_gnt
);

    req_id_t r_ptr;

    always_comb begin
        o_gnt = '0;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = id_onehot(r_ptr);
            default: o_gnt = '0;
        endcase
    end

    // The pointer favours the requester that did not just win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_gnt[1];
        end
    end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Arbitrates two requesters onto one SDP BRAM and routes tagged read data back after RD_LAT cycles.
module sdp_ram_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    wr_req,
    input  logic [NUM_REQ*AW-1:0] wr_addr,
    input  logic [NUM_REQ*DW-1:0] wr_data,
    output logic [NUM_REQ-1:0]    wr_gnt,
    input  logic [NUM_REQ-1:0]    rd_req,
    input  logic [NUM_REQ*AW-1:0] rd_addr,
    output logic [NUM_REQ-1:0]    rd_gnt,
    output logic [NUM_REQ-1:0]    rd_rsp_vld,
    output logic [DW-1:0]         rd_rsp_data,
    output logic                  ram_wea,
    output logic [AW-1:0]         ram_addra,
    output logic [DW-1:0]         ram_dina,
    output logic                  ram_enb,
    output logic [AW-1:0]         ram_addrb,
    input  logic [DW-1:0]         ram_doutb
);

    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [NUM_REQ-1:0] w_wr_gnt;
    logic [NUM_REQ-1:0] w_rd_gnt;
    logic               w_wr_acc;
    logic               w_rd_acc;
    req_id_t            w_wr_id;
    req_id_t            w_rd_id;
    logic               w_rsp_vld;

    logic               r_wea;
    logic [AW-1:0]      r_addra;
    logic [DW-1:0]      r_dina;
    logic [AW-1:0]      r_addrb;
    logic [LAT:0]       r_vld_p;
    req_id_t            r_id_p [LAT:0];

    assign w_wr_acc = |(wr_req & w_wr_gnt);
    assign w_rd_acc = |(rd_req & w_rd_gnt);
    assign w_wr_id  = w_wr_gnt[1];
    assign w_rd_id  = w_rd_gnt[1];

    rr_arb2 u_wr_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (wr_req),
        .i_accept (w_wr_acc),
        .o_gnt    (w_wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (rd_req),
        .i_accept (w_rd_acc),
        .o_gnt    (w_rd_gnt)
    );

    // Stage p0: port A registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_wea <= w_wr_acc;
            if (w_wr_acc) begin
                r_addra <= w_wr_id ? wr_addr[AW +: AW] : wr_addr[0 +: AW];
                r_dina  <= w_wr_id ? wr_data[DW +: DW] : wr_data[0 +: DW];
            end
        end
    end

    // Stage p0 is the enb cycle; stage pLAT lines up with valid doutb
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addrb <= '0;
            r_vld_p <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_id_p[k] <= 1'b0;
            end
        end else begin
            r_vld_p   <= {r_vld_p[LAT-1:0], w_rd_acc};
            r_id_p[0] <= w_rd_id;
            for (int k = 1; k <= LAT; k++) begin
                r_id_p[k] <= r_id_p[k-1];
            end
            if (w_rd_acc) begin
                r_addrb <= w_rd_id ? rd_addr[AW +: AW] : rd_addr[0 +: AW];
            end
        end
    end

    assign w_rsp_vld   = r_vld_p[LAT];
    assign rd_rsp_vld  = w_rsp_vld ? id_onehot(r_id_p[LAT]) : '0;
    assign rd_rsp_data = w_rsp_vld ? ram_doutb : '0;

    assign wr_gnt    = w_wr_gnt;
    assign rd_gnt    = w_rd_gnt;
    assign ram_wea   = r_wea;
    assign ram_addra = r_addra;
    assign ram_dina  = r_dina;
    assign ram_enb   = r_vld_p[0];
    assign ram_addrb = r_addrb;

endmodule
